axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register slave used in the current BFM bench.
- Provides N_RW read/write control registers, with byte strobes and a per-register write pulse.
- Provides N_RO read-only status registers, sampled from fabric inputs.
- Returns SLVERR on decode errors; AW and W may arrive in either order.
- Sits between the PS AXI interconnect and the denoising pipeline's control/status logic.

Parameters:
- DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- ADDR_WIDTH, 6: byte address width; must cover (N_RW+N_RO+1) words.
- N_RW, 4: number of read/write control registers (1..16).
- N_RO, 4: number of read-only status registers (0..16).
- RESET_VAL, 0: reset value of every control register.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- ctrl_o  out  N_RW*DATA_WIDTH  control register contents; register k at slice k.
- ctrl_wr_pulse_o  out  N_RW  one-cycle pulse on the cycle after register k is written.
- status_i  in  N_RO*DATA_WIDTH  status inputs; synchronous to ACLK.

Behaviour:
- Reset values:
  - All READY, BVALID, RVALID = 0; BRESP/RRESP = 0; RDATA = 0.
  - ctrl_o = RESET_VAL per register; ctrl_wr_pulse_o = 0.
  - READY outputs are registered and rise on the first edge after ARESET deasserts.
- Decode:
  - ADDR_LSB = clog2(DATA_WIDTH/8); word index idx = addr[ADDR_WIDTH-1:ADDR_LSB]; low bits ignored.
  - idx < N_RW: read/write register.
  - N_RW <= idx < N_RW+N_RO: read-only register.
  - Any other idx: unmapped.
- Write FSM, states WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP:
  - WR_IDLE: AWREADY=1, WREADY=1. Both handshakes in the same cycle -> WR_RESP. AW only -> WR_HAVE_ADDR. W only -> WR_HAVE_DATA.
  - WR_HAVE_ADDR: WREADY=1, AWREADY=0; W handshake -> WR_RESP.
  - WR_HAVE_DATA: AWREADY=1, WREADY=0; AW handshake -> WR_RESP.
  - Register update and BVALID assertion occur on the same edge as entry to WR_RESP. Latency is 1 cycle from the completing handshake.
  - Byte lanes with WSTRB=0 are preserved; WSTRB=0 overall is still OKAY and still pulses.
  - Write to a read-only or unmapped register: no state change, no pulse, BRESP=SLVERR (2'b10); otherwise BRESP=OKAY.
  - WR_RESP: AWREADY=WREADY=0; BVALID held until BREADY; then -> WR_IDLE. A BREADY already high gives a 1-cycle response.
  - One outstanding write only.
- Read FSM, states RD_IDLE, RD_RESP:
  - RD_IDLE: ARREADY=1. On handshake, RDATA is registered from ctrl/status (pre-edge value) -> RD_RESP.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
  - RD_RESP: ARREADY=0; RVALID, RDATA and RRESP held stable until RREADY -> RD_IDLE.
- Simultaneous read and write to the same register in the same cycle: the read returns the old value.
- The write and read channels are fully independent.
- ARESET mid-transaction: all in-flight transactions are dropped; outputs return to reset values asynchronously.

Optional Feature:
- Macro: AXIL_REGBANK_IRQ_EN.
- When defined:
  - Adds ports irq_src_i (in, DATA_WIDTH) and irq_o (out, 1).
  - Adds a sticky IRQ status register at idx = N_RW+N_RO. Each bit is set when the corresponding irq_src_i bit is 1 on an edge.
  - A write of 1 to a bit clears it (W1C, strobe-qualified). Set wins over clear in the same cycle.
  - irq_o = OR of all status bits, registered; reset value 0.
- When undefined: those ports are absent and that index is unmapped (SLVERR).

Decomposition:
- Package axil_regbank_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - wr_state_t and rd_state_t enums.
  - addr_lsb(DATA_WIDTH) function.
- Sub-module axil_regbank_wr_join: implements the AW/W join FSM. Outputs a one-cycle wr_en with latched idx, data and strobe; the bank owns the registers and the B channel.

Test Plan:
- Reset default: after reset, read idx 0..3 -> RDATA=0x00000000, RRESP=OKAY. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> same values. ctrl_wr_pulse_o[k] pulses once per write.
- Channel ordering:
  - W 0xDEADBEEF presented 3 cycles before AW 0x4: BVALID asserts 1 cycle after the AW handshake and ctrl reg1 = 0xDEADBEEF.
  - AW-first ordering gives the same result.
- Byte strobes: reg0=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x11BB33DD.
- Read-only and unmapped:
  - status_i slice 0 = 0xCAFE0001; read 0x10 -> 0xCAFE0001, OKAY.
  - Write 0x10 -> SLVERR, value unchanged.
  - Read 0x3C -> RDATA 0, SLVERR.
- Backpressure and reset:
  - BREADY/RREADY held low 10 cycles: BVALID/RVALID and data stay stable, and no new AW/AR is accepted.
  - ARESET asserted mid-WR_HAVE_ADDR: BVALID=0 and ctrl regs = RESET_VAL.
- IRQ (AXIL_REGBANK_IRQ_EN):
  - irq_src_i bit3 pulses -> irq_o=1; write 0x8 to the IRQ register -> irq_o=0 next cycle.
  - Simultaneous set and clear of bit3 -> bit stays 1.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared response codes, FSM state types and the address-alignment helper
// for the axil_regbank AXI4-Lite register bank.
package axil_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'b00,
      WR_HAVE_ADDR = 2'b01,
      WR_HAVE_DATA = 2'b10,
      WR_RESP      = 2'b11
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axil_regbank_wr_join.sv
// AW/W join for axil_regbank: accepts address and data in either order and
// issues a single-cycle wr_en once both halves of a write are present.
module axil_regbank_wr_join
   import axil_regbank_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic                    resp_done,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb
);

   wr_state_t                 state_r;
   wr_state_t                 state_nxt_s;
   logic                      awready_r;
   logic                      wready_r;
   logic                      wr_en_s;
   logic                      aw_hs_s;
   logic                      w_hs_s;
   logic [ADDR_WIDTH-1:0]     addr_r;
   logic [DATA_WIDTH-1:0]     data_r;
   logic [DATA_WIDTH/8-1:0]   strb_r;

   assign aw_hs_s = awvalid && awready_r;
   assign w_hs_s  = wvalid && wready_r;

   // Next-state decode; wr_en fires on the handshake that completes the pair
   always_comb begin
      state_nxt_s = state_r;
      wr_en_s     = 1'b0;
      case (state_r)
         WR_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               state_nxt_s = WR_RESP;
               wr_en_s     = 1'b1;
            end else if (aw_hs_s) begin
               state_nxt_s = WR_HAVE_ADDR;
            end else if (w_hs_s) begin
               state_nxt_s = WR_HAVE_DATA;
            end else begin
               state_nxt_s = WR_IDLE;
            end
         end
         WR_HAVE_ADDR: begin
            if (w_hs_s) begin
               state_nxt_s = WR_RESP;
               wr_en_s     = 1'b1;
            end else begin
               state_nxt_s = WR_HAVE_ADDR;
            end
         end
         WR_HAVE_DATA: begin
            if (aw_hs_s) begin
               state_nxt_s = WR_RESP;
               wr_en_s     = 1'b1;
            end else begin
               state_nxt_s = WR_HAVE_DATA;
            end
         end
         WR_RESP: begin
            if (resp_done) begin
               state_nxt_s = WR_IDLE;
            end else begin
               state_nxt_s = WR_RESP;
            end
         end
         default: state_nxt_s = WR_IDLE;
      endcase
   end

   // State, registered READYs and the half-transaction holding registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= WR_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         addr_r    <= {ADDR_WIDTH{1'b0}};
         data_r    <= {DATA_WIDTH{1'b0}};
         strb_r    <= {(DATA_WIDTH/8){1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         awready_r <= (state_nxt_s == WR_IDLE) || (state_nxt_s == WR_HAVE_DATA);
         wready_r  <= (state_nxt_s == WR_IDLE) || (state_nxt_s == WR_HAVE_ADDR);
         if (aw_hs_s) addr_r <= awaddr;
         if (w_hs_s) begin
            data_r <= wdata;
            strb_r <= wstrb;
         end
      end
   end

   assign awready = awready_r;
   assign wready  = wready_r;
   assign wr_en   = wr_en_s;
   assign wr_addr = aw_hs_s ? awaddr : addr_r;
   assign wr_data = w_hs_s ? wdata : data_r;
   assign wr_strb = w_hs_s ? wstrb : strb_r;

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: N_RW control registers, N_RO status registers.
// Define AXIL_REGBANK_IRQ_EN to add a sticky W1C IRQ register and irq_o.
module axil_regbank
   import axil_regbank_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    N_RW       = 4,
   parameter int                    N_RO       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{1'b0}}
) (
   input  logic                                    ACLK,
   input  logic                                    ARESET,
   input  logic [ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
   input  logic [2:0]                              S_AXI_AWPROT,
   input  logic                                    S_AXI_AWVALID,
   output logic                                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]                   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
   input  logic                                    S_AXI_WVALID,
   output logic                                    S_AXI_WREADY,
   output logic [1:0]                              S_AXI_BRESP,
   output logic                                    S_AXI_BVALID,
   input  logic                                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
   input  logic [2:0]                              S_AXI_ARPROT,
   input  logic                                    S_AXI_ARVALID,
   output logic                                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]                   S_AXI_RDATA,
   output logic [1:0]                              S_AXI_RRESP,
   output logic                                    S_AXI_RVALID,
   input  logic                                    S_AXI_RREADY,
   output logic [N_RW*DATA_WIDTH-1:0]              ctrl_o,
   output logic [N_RW-1:0]                         ctrl_wr_pulse_o,
   input  logic [((N_RO>0)?N_RO:1)*DATA_WIDTH-1:0] status_i
`ifdef AXIL_REGBANK_IRQ_EN
   ,
   input  logic [DATA_WIDTH-1:0]                   irq_src_i,
   output logic                                    irq_o
`endif
);

   localparam int          ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam logic [31:0] RW_END   = 32'(N_RW);
   localparam logic [31:0] RO_END   = 32'(N_RW + N_RO);

   logic                          wr_en_s;
   logic [ADDR_WIDTH-1:0]         wr_addr_s;
   logic [DATA_WIDTH-1:0]         wr_data_s;
   logic [DATA_WIDTH/8-1:0]       wr_strb_s;
   logic [DATA_WIDTH-1:0]         wmask_s;
   logic [31:0]                   widx_s;
   logic [31:0]                   ridx_s;
   logic                          wr_rw_s;
   logic                          wr_ok_s;
   logic [N_RW-1:0][DATA_WIDTH-1:0] ctrl_r;
   logic [N_RW-1:0]               pulse_nxt_s;
   logic [N_RW-1:0]               pulse_r;
   logic                          bvalid_r;
   logic [1:0]                    bresp_r;
   rd_state_t                     rd_state_r;
   rd_state_t                     rd_state_nxt_s;
   logic                          arready_r;
   logic                          rvalid_r;
   logic                          ar_hs_s;
   logic [DATA_WIDTH-1:0]         rdata_r;
   logic [DATA_WIDTH-1:0]         rdata_nxt_s;
   logic [1:0]                    rresp_r;
   logic [1:0]                    rresp_nxt_s;
   logic                          unused_bits_s;

   axil_regbank_wr_join #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_join (
      .clk       (ACLK),
      .rst       (ARESET),
      .awaddr    (S_AXI_AWADDR),
      .awvalid   (S_AXI_AWVALID),
      .awready   (S_AXI_AWREADY),
      .wdata     (S_AXI_WDATA),
      .wstrb     (S_AXI_WSTRB),
      .wvalid    (S_AXI_WVALID),
      .wready    (S_AXI_WREADY),
      .resp_done (bvalid_r && S_AXI_BREADY),
      .wr_en     (wr_en_s),
      .wr_addr   (wr_addr_s),
      .wr_data   (wr_data_s),
      .wr_strb   (wr_strb_s)
   );

   assign widx_s  = 32'(wr_addr_s[ADDR_WIDTH-1:ADDR_LSB]);
   assign ridx_s  = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);
   assign wr_rw_s = widx_s < RW_END;
   assign unused_bits_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            wr_addr_s[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   // Byte-lane mask and per-register write decode
   always_comb begin
      wmask_s     = {DATA_WIDTH{1'b0}};
      pulse_nxt_s = {N_RW{1'b0}};
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
         wmask_s[b*8 +: 8] = {8{wr_strb_s[b]}};
      end
      for (int k = 0; k < N_RW; k++) begin
         pulse_nxt_s[k] = wr_en_s && (widx_s == 32'(k));
      end
   end

   // Control registers (strobe-merged) and the write pulse one cycle later
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ctrl_r  <= {N_RW{RESET_VAL}};
         pulse_r <= {N_RW{1'b0}};
      end else begin
         for (int k = 0; k < N_RW; k++) begin
            if (pulse_nxt_s[k]) ctrl_r[k] <= (ctrl_r[k] & ~wmask_s) | (wr_data_s & wmask_s);
         end
         pulse_r <= pulse_nxt_s;
      end
   end

`ifdef AXIL_REGBANK_IRQ_EN
   logic                  wr_irq_s;
   logic [DATA_WIDTH-1:0] irq_clr_s;
   logic [DATA_WIDTH-1:0] irq_nxt_s;
   logic [DATA_WIDTH-1:0] irq_r;
   logic                  irq_out_r;

   assign wr_irq_s  = widx_s == RO_END;
   assign wr_ok_s   = wr_rw_s || wr_irq_s;
   assign irq_clr_s = (wr_en_s && wr_irq_s) ? (wr_data_s & wmask_s) : {DATA_WIDTH{1'b0}};
   // New sources are OR-ed in after the clear so a coincident set survives
   assign irq_nxt_s = (irq_r & ~irq_clr_s) | irq_src_i;

   // Sticky IRQ status and its registered summary
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         irq_r     <= {DATA_WIDTH{1'b0}};
         irq_out_r <= 1'b0;
      end else begin
         irq_r     <= irq_nxt_s;
         irq_out_r <= |irq_nxt_s;
      end
   end

   assign irq_o = irq_out_r;
`else
   assign wr_ok_s = wr_rw_s;
`endif

   // Write response channel
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
      end else if (wr_en_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_r && S_AXI_BREADY) begin
         bvalid_r <= 1'b0;
      end
   end

   assign ar_hs_s = S_AXI_ARVALID && arready_r;

   // Read FSM next state
   always_comb begin
      rd_state_nxt_s = rd_state_r;
      case (rd_state_r)
         RD_IDLE: rd_state_nxt_s = ar_hs_s ? RD_RESP : RD_IDLE;
         RD_RESP: rd_state_nxt_s = S_AXI_RREADY ? RD_IDLE : RD_RESP;
         default: rd_state_nxt_s = RD_IDLE;
      endcase
   end

   // Read mux; unmatched indices fall through to zero data with SLVERR
   always_comb begin
      rdata_nxt_s = {DATA_WIDTH{1'b0}};
      rresp_nxt_s = RESP_SLVERR;
      for (int k = 0; k < N_RW; k++) begin
         rdata_nxt_s = (ridx_s == 32'(k)) ? ctrl_r[k] : rdata_nxt_s;
         rresp_nxt_s = (ridx_s == 32'(k)) ? RESP_OKAY : rresp_nxt_s;
      end
      for (int k = 0; k < N_RO; k++) begin
         rdata_nxt_s = (ridx_s == 32'(N_RW + k)) ? status_i[k*DATA_WIDTH +: DATA_WIDTH] : rdata_nxt_s;
         rresp_nxt_s = (ridx_s == 32'(N_RW + k)) ? RESP_OKAY : rresp_nxt_s;
      end
`ifdef AXIL_REGBANK_IRQ_EN
      rdata_nxt_s = (ridx_s == RO_END) ? irq_r : rdata_nxt_s;
      rresp_nxt_s = (ridx_s == RO_END) ? RESP_OKAY : rresp_nxt_s;
`endif
   end

   // Read state, registered ARREADY/RVALID and captured response
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rresp_r    <= RESP_OKAY;
      end else begin
         rd_state_r <= rd_state_nxt_s;
         arready_r  <= rd_state_nxt_s == RD_IDLE;
         rvalid_r   <= rd_state_nxt_s == RD_RESP;
         if (ar_hs_s) begin
            rdata_r <= rdata_nxt_s;
            rresp_r <= rresp_nxt_s;
         end
      end
   end

   assign S_AXI_BVALID    = bvalid_r;
   assign S_AXI_BRESP     = bresp_r;
   assign S_AXI_ARREADY   = arready_r;
   assign S_AXI_RVALID    = rvalid_r;
   assign S_AXI_RDATA     = rdata_r;
   assign S_AXI_RRESP     = rresp_r;
   assign ctrl_o          = ctrl_r;
   assign ctrl_wr_pulse_o = pulse_r;

endmodule

// File: tb/tb_axil_regbank.sv
// Directed self-checking bench for axil_regbank (default 32-bit, 4 RW + 4 RO).
// IRQ steps are compiled in when AXIL_REGBANK_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_axil_regbank;

   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int NRW = 4;
   localparam int NRO = 4;

   logic              ACLK = 1'b0;
   logic              ARESET = 1'b1;
   logic [AW-1:0]     S_AXI_AWADDR = '0;
   logic [2:0]        S_AXI_AWPROT = 3'b000;
   logic              S_AXI_AWVALID = 1'b0;
   logic              S_AXI_AWREADY;
   logic [DW-1:0]     S_AXI_WDATA = '0;
   logic [DW/8-1:0]   S_AXI_WSTRB = '0;
   logic              S_AXI_WVALID = 1'b0;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY = 1'b1;
   logic [AW-1:0]     S_AXI_ARADDR = '0;
   logic [2:0]        S_AXI_ARPROT = 3'b000;
   logic              S_AXI_ARVALID = 1'b0;
   logic              S_AXI_ARREADY;
   logic [DW-1:0]     S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY = 1'b1;
   logic [NRW*DW-1:0] ctrl_o;
   logic [NRW-1:0]    ctrl_wr_pulse_o;
   logic [NRO*DW-1:0] status_i = '0;
`ifdef AXIL_REGBANK_IRQ_EN
   logic [DW-1:0]     irq_src_i = '0;
   logic              irq_o;
`endif

   int tests = 0;
   int fails = 0;
   int pulse_cnt [NRW];

   always #5 ACLK = ~ACLK;

   axil_regbank dut (
      .ACLK            (ACLK),
      .ARESET          (ARESET),
      .S_AXI_AWADDR    (S_AXI_AWADDR),
      .S_AXI_AWPROT    (S_AXI_AWPROT),
      .S_AXI_AWVALID   (S_AXI_AWVALID),
      .S_AXI_AWREADY   (S_AXI_AWREADY),
      .S_AXI_WDATA     (S_AXI_WDATA),
      .S_AXI_WSTRB     (S_AXI_WSTRB),
      .S_AXI_WVALID    (S_AXI_WVALID),
      .S_AXI_WREADY    (S_AXI_WREADY),
      .S_AXI_BRESP     (S_AXI_BRESP),
      .S_AXI_BVALID    (S_AXI_BVALID),
      .S_AXI_BREADY    (S_AXI_BREADY),
      .S_AXI_ARADDR    (S_AXI_ARADDR),
      .S_AXI_ARPROT    (S_AXI_ARPROT),
      .S_AXI_ARVALID   (S_AXI_ARVALID),
      .S_AXI_ARREADY   (S_AXI_ARREADY),
      .S_AXI_RDATA     (S_AXI_RDATA),
      .S_AXI_RRESP     (S_AXI_RRESP),
      .S_AXI_RVALID    (S_AXI_RVALID),
      .S_AXI_RREADY    (S_AXI_RREADY),
      .ctrl_o          (ctrl_o),
      .ctrl_wr_pulse_o (ctrl_wr_pulse_o),
      .status_i        (status_i)
`ifdef AXIL_REGBANK_IRQ_EN
      ,
      .irq_src_i       (irq_src_i),
      .irq_o           (irq_o)
`endif
   );

   // Each pulse is high for exactly one cycle, so it is seen at one rising edge
   always @(posedge ACLK) begin
      for (int k = 0; k < NRW; k++) begin
         if (ctrl_wr_pulse_o[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int   n;
      logic aw_hs;
      logic w_hs;
      @(negedge ACLK);
      S_AXI_AWADDR = addr;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA  = data;  S_AXI_WSTRB   = strb;  S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1;
      n = 0;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(negedge ACLK);
         n++;
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs)  S_AXI_WVALID  = 1'b0;
      end
      while (!S_AXI_BVALID && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("wr_done_in_budget", 64'(n < 20), 64'd1);
      resp = S_AXI_BRESP;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      @(negedge ACLK);
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp);
      int n;
      @(negedge ACLK);
      S_AXI_ARADDR = addr;  S_AXI_ARVALID = 1'b1;  S_AXI_RREADY = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      while (!S_AXI_RVALID && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("rd_done_in_budget", 64'(n < 20), 64'd1);
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      @(negedge ACLK);
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;

      // Reset state
      status_i = {32'h4444_0004, 32'h3333_0003, 32'h0BAD_F00D, 32'hCAFE_0001};
      repeat (3) @(negedge ACLK);
      chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd0);
      chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 64'd0);
      chk("rst_rdata", S_AXI_RDATA, 64'd0);
      chk("rst_ctrl", {ctrl_o[127:96] | ctrl_o[95:64], ctrl_o[63:32] | ctrl_o[31:0]}, 64'd0);
      chk("rst_pulse", ctrl_wr_pulse_o, 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);

      // Defaults, then write/readback with one pulse per write
      for (int i = 0; i < 4; i++) begin
         axi_read(AW'(i * 4), rd, resp);
         chk("rd_default", {resp, rd}, 64'h0);
      end
      for (int i = 0; i < 4; i++) begin
         axi_write(AW'(i * 4), 32'(i + 1), 4'hF, resp);
         chk("wr_okay", resp, 64'd0);
      end
      for (int i = 0; i < 4; i++) begin
         chk("pulse_once", pulse_cnt[i], 64'd1);
         axi_read(AW'(i * 4), rd, resp);
         chk("rd_back", {resp, rd}, 64'(i + 1));
      end

      // W three cycles ahead of AW
      @(negedge ACLK);
      S_AXI_WDATA = 32'hDEAD_BEEF;  S_AXI_WSTRB = 4'hF;  S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_WVALID = 1'b0;
      chk("w_first_hold", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b100);
      repeat (2) @(negedge ACLK);
      S_AXI_AWADDR = 6'h04;  S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      chk("w_first_bvalid", {S_AXI_BVALID, S_AXI_BRESP}, 64'b100);
      chk("w_first_reg1", ctrl_o[63:32], 64'hDEAD_BEEF);
      @(negedge ACLK);
      chk("w_first_bdone", S_AXI_BVALID, 64'd0);

      // AW one cycle ahead of W
      S_AXI_AWADDR = 6'h08;  S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      chk("aw_first_hold", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b010);
      @(negedge ACLK);
      S_AXI_WDATA = 32'h1234_5678;  S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_WVALID = 1'b0;
      chk("aw_first_bvalid", {S_AXI_BVALID, S_AXI_BRESP}, 64'b100);
      chk("aw_first_reg2", ctrl_o[95:64], 64'h1234_5678);
      @(negedge ACLK);
      chk("pulse_reg1_reg2", {pulse_cnt[1][7:0], pulse_cnt[2][7:0]}, 64'h0202);

      // Byte strobes, including an all-zero strobe
      axi_write(6'h00, 32'h1122_3344, 4'hF, resp);
      axi_write(6'h00, 32'hAABB_CCDD, 4'b0101, resp);
      axi_read(6'h00, rd, resp);
      chk("strb_merge", {resp, rd}, 64'h11BB_33DD);
      axi_write(6'h0C, 32'hFFFF_FFFF, 4'h0, resp);
      chk("strb_zero_resp", resp, 64'd0);
      chk("strb_zero_pulse", pulse_cnt[3], 64'd2);
      axi_read(6'h0C, rd, resp);
      chk("strb_zero_keep", rd, 64'd4);

      // Read-only and unmapped space
      axi_read(6'h10, rd, resp);
      chk("ro_first", {resp, rd}, 64'hCAFE_0001);
      axi_read(6'h1C, rd, resp);
      chk("ro_last", {resp, rd}, 64'h4444_0004);
      axi_write(6'h10, 32'h5A5A_5A5A, 4'hF, resp);
      chk("ro_write_slverr", resp, 64'd2);
      chk("ro_write_ctrl_lo", ctrl_o[63:0], 64'hDEAD_BEEF_11BB_33DD);
      chk("ro_write_ctrl_hi", ctrl_o[127:64], 64'h0000_0004_1234_5678);
      chk("ro_write_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 64'd9);
      axi_read(6'h3C, rd, resp);
      chk("unmapped_read", {resp, rd}, 64'h2_0000_0000);
`ifndef AXIL_REGBANK_IRQ_EN
      axi_read(6'h20, rd, resp);
      chk("irq_idx_unmapped", {resp, rd}, 64'h2_0000_0000);
`endif

      // Write response backpressure
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      S_AXI_AWADDR = 6'h0C;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h0000_0055;  S_AXI_WSTRB = 4'hF;  S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;  S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("b_stall", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 64'b10000);
         @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      chk("b_release", {S_AXI_BVALID, S_AXI_AWREADY}, 64'b01);
      chk("b_stall_reg3", ctrl_o[127:96], 64'h55);

      // Read data backpressure
      S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 6'h04;  S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("r_stall", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_ARREADY, S_AXI_RDATA}, {4'b1000, 32'hDEAD_BEEF});
         @(negedge ACLK);
      end
      S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      chk("r_release", {S_AXI_RVALID, S_AXI_ARREADY}, 64'b01);

      // Read and write of reg1 on the same edge: read sees the old value
      S_AXI_AWADDR = 6'h04;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h0F0F_0F0F;  S_AXI_WSTRB = 4'hF;  S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 6'h04;  S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;  S_AXI_WVALID = 1'b0;  S_AXI_ARVALID = 1'b0;
      chk("rw_same_rd_old", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'hDEAD_BEEF});
      chk("rw_same_wr_new", {S_AXI_BVALID, ctrl_o[63:32]}, {1'b1, 32'h0F0F_0F0F});
      @(negedge ACLK);

`ifdef AXIL_REGBANK_IRQ_EN
      // Sticky IRQ: set, W1C clear, and set winning over clear
      irq_src_i = 32'h8;
      @(negedge ACLK);
      irq_src_i = 32'h0;
      chk("irq_set", irq_o, 64'd1);
      axi_read(6'h20, rd, resp);
      chk("irq_status", {resp, rd}, 64'h8);
      axi_write(6'h20, 32'h8, 4'hF, resp);
      chk("irq_clear", {resp, irq_o}, 64'd0);
      irq_src_i = 32'h8;
      axi_write(6'h20, 32'h8, 4'hF, resp);
      irq_src_i = 32'h0;
      axi_read(6'h20, rd, resp);
      chk("irq_set_wins", {irq_o, rd}, {1'b1, 32'h8});
`endif

      // Reset while holding an address
      S_AXI_AWADDR = 6'h00;  S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      chk("have_addr", {S_AXI_AWREADY, S_AXI_WREADY}, 64'b01);
      #2 ARESET = 1'b1;
      #1;
      chk("mid_rst_outputs", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, ctrl_wr_pulse_o}, 64'd0);
      chk("mid_rst_ctrl_lo", ctrl_o[63:0], 64'd0);
      chk("mid_rst_ctrl_hi", ctrl_o[127:64], 64'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      axi_read(6'h04, rd, resp);
      chk("after_rst_read", {resp, rd}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
